// File: rtl/fb_reader.sv
// Wishbone classic read master that streams the framebuffer, one word per pixel,
// into a first-word-fall-through FIFO presented as a valid/ready pixel stream.
module fb_reader #(
    parameter int HDISP       = 800,
    parameter int VDISP       = 480,
    parameter int FIFO_DEPTH  = 16,
    parameter int FAIR_PERIOD = 64,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          wshb_cyc,
    output logic          wshb_stb,
    output logic          wshb_we,
    output logic [3:0]    wshb_sel,
    output logic [2:0]    wshb_cti,
    output logic [1:0]    wshb_bte,
    output logic [31:0]   wshb_adr,
    input  logic [31:0]   wshb_dat_sm,
    input  logic          wshb_ack,
    input  logic          restart,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [23:0]   pix_data,
    output logic          pix_sof,
    output logic [LW-1:0] fifo_level
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = (FAIR_PERIOD > 1) ? $clog2(FAIR_PERIOD) : 1;
    localparam logic [31:0] LAST_ADR = 32'(4 * (HDISP * VDISP - 1));

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   adr;
    logic [FW-1:0] fair;
    logic [24:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nxt;
    logic          push, pop, fair_wrap, full_nxt;
    logic          unused_hi;

    assign unused_hi = ^wshb_dat_sm[31:24];

    // An ack outside REQ or coinciding with restart never reaches the FIFO
    assign push      = rst_n && !restart && (state == REQ) && wshb_ack;
    assign pop       = (level != '0) && pix_ready;
    assign level_nxt = level + LW'(push) - LW'(pop);
    assign full_nxt  = (level_nxt == LW'(FIFO_DEPTH));
    assign fair_wrap = (fair == FW'(FAIR_PERIOD - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, GAP: state_nxt = full_nxt ? IDLE : REQ;
            REQ: begin
                if (wshb_ack) begin
                    if (fair_wrap)     state_nxt = GAP;
                    else if (full_nxt) state_nxt = IDLE;
                    else               state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state    <= IDLE;
            wshb_cyc <= 1'b0;
            adr      <= '0;
            fair     <= '0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            wshb_cyc <= (state_nxt == REQ);
            level    <= level_nxt;
            if (push) begin
                adr    <= (adr == LAST_ADR) ? '0 : adr + 32'd4;
                fair   <= fair_wrap ? '0 : fair + FW'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {adr == '0, wshb_dat_sm[23:0]};
    end

    assign wshb_stb   = wshb_cyc;
    assign wshb_we    = 1'b0;
    assign wshb_sel   = 4'hF;
    assign wshb_cti   = 3'd0;
    assign wshb_bte   = 2'd0;
    assign wshb_adr   = adr;
    assign pix_valid  = (level != '0);
    assign {pix_sof, pix_data} = mem[rd_ptr];
    assign fifo_level = level;
endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on a 4x2 frame: vector table, bus/pixel scoreboard,
// and hand sequences for backpressure, fair-play gaps, wait states and restart.
module tb_fb_reader;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wshb_cyc, wshb_stb, wshb_we, wshb_ack;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_adr, wshb_dat_sm;
    logic        restart = 1'b0, pix_valid, pix_ready = 1'b0, pix_sof;
    logic [23:0] pix_data;
    logic [4:0]  fifo_level;

    logic        ack_en = 1'b0;
    logic [3:0]  wait_n = 4'd0;
    logic [3:0]  wait_cnt = 4'd0;

    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    fb_reader #(.HDISP(4), .VDISP(2), .FIFO_DEPTH(16), .FAIR_PERIOD(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
        .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
        .wshb_adr(wshb_adr), .wshb_dat_sm(wshb_dat_sm), .wshb_ack(wshb_ack),
        .restart(restart), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .fifo_level(fifo_level)
    );

    // Slave: returns its address (with junk in the top byte) after wait_n wait states
    assign wshb_ack    = ack_en && wshb_cyc && wshb_stb && (wait_cnt >= wait_n);
    assign wshb_dat_sm = {8'hAB, wshb_adr[23:0]};
    always @(posedge clk) begin
        if (!(wshb_cyc && wshb_stb) || wshb_ack) wait_cnt <= 4'd0;
        else wait_cnt <= wait_cnt + 4'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Scoreboard: expected address walk and FIFO contents, sampled mid-cycle
    logic [24:0] q[$];
    logic [31:0] exp_adr = 32'd0;
    bit          mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level_vs_model", 32'(fifo_level), 32'(q.size()));
            chk("valid_vs_model", 32'(pix_valid), 32'(q.size() != 0));
            chk("stb_eq_cyc", 32'(wshb_stb), 32'(wshb_cyc));
            if (restart) begin
                q.delete();
                exp_adr = 32'd0;
            end else begin
                if (pix_valid && pix_ready && q.size() != 0) begin
                    chk("pix_data", 32'(pix_data), 32'(q[0][23:0]));
                    chk("pix_sof", 32'(pix_sof), 32'(q[0][24]));
                    void'(q.pop_front());
                end
                if (wshb_cyc && wshb_stb && wshb_ack) begin
                    chk("adr_seq", wshb_adr, exp_adr);
                    q.push_back({exp_adr == 32'd0, exp_adr[23:0]});
                    exp_adr = (exp_adr == 32'd28) ? 32'd0 : exp_adr + 32'd4;
                end
            end
        end
    end

    typedef struct {
        logic        rdy, ack, rs;
        logic        cyc;
        logic [31:0] adr;
        logic        vld;
        logic [23:0] data;
        logic        sof;
        logic [4:0]  lvl;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rs, input logic cyc,
                                input logic [31:0] adr, input logic vld,
                                input logic [23:0] d, input logic sof, input logic [4:0] lvl);
        vec_t v;
        v.rdy = rdy; v.ack = 1'b1; v.rs = rs; v.cyc = cyc; v.adr = adr;
        v.vld = vld; v.data = d; v.sof = sof; v.lvl = lvl;
        return v;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[18];
        int acks, gaps, g1, g2, dbl, stable_bad;
        bit seen, prev_low, ok;
        logic [31:0] hold;

        //              rdy   rs    cyc   adr     vld   data    sof   lvl
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 24'd0,  1'b0, 5'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 24'd0,  1'b0, 5'd0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 24'd0,  1'b1, 5'd1);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 24'd4,  1'b0, 5'd1);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 24'd8,  1'b0, 5'd1);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 32'd16, 1'b1, 24'd12, 1'b0, 5'd1);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 32'd20, 1'b1, 24'd16, 1'b0, 5'd1);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 24'd20, 1'b0, 5'd1);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 32'd28, 1'b1, 24'd24, 1'b0, 5'd1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 32'd0,  1'b1, 24'd28, 1'b0, 5'd1);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 24'd0,  1'b1, 5'd1);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 32'd8,  1'b1, 24'd4,  1'b0, 5'd1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'd12, 1'b1, 24'd8,  1'b0, 5'd1);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 32'd16, 1'b1, 24'd8,  1'b0, 5'd2);
        tbl[14] = mk(1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 24'd8,  1'b0, 5'd3);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 24'd0,  1'b0, 5'd0);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 24'd0,  1'b0, 5'd0);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 24'd0,  1'b1, 5'd1);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(wshb_cyc), 32'd0);
        chk("rst_stb", 32'(wshb_stb), 32'd0);
        chk("rst_adr", wshb_adr, 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("const_bus", {20'd0, wshb_we, wshb_sel, wshb_cti, wshb_bte, 2'd0}, {20'd0, 1'b0, 4'hF, 3'd0, 2'd0, 2'd0});
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            pix_ready = tbl[i].rdy;
            ack_en    = tbl[i].ack;
            restart   = tbl[i].rs;
            @(negedge clk);
            chk($sformatf("vec%0d_cyc", i), 32'(wshb_cyc), 32'(tbl[i].cyc));
            chk($sformatf("vec%0d_adr", i), wshb_adr, tbl[i].adr);
            chk($sformatf("vec%0d_lvl", i), 32'(fifo_level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_vld", i), 32'(pix_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("vec%0d_data", i), 32'(pix_data), 32'(tbl[i].data));
                chk($sformatf("vec%0d_sof", i), 32'(pix_sof), 32'(tbl[i].sof));
            end
            tick();
        end
        restart = 1'b0;

        // Backpressure: fill to 16 then stall, single pop restarts the bus
        pix_ready = 1'b0;
        ack_en    = 1'b1;
        do_restart();
        acks = 0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wshb_cyc && wshb_ack) acks++;
            if (wshb_cyc) seen = 1'b1;
            else if (seen) break;
        end
        chk("bp_acks", 32'(acks), 32'd16);
        chk("bp_level", 32'(fifo_level), 32'd16);
        chk("bp_cyc_low", 32'(wshb_cyc), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_cyc_stays_low", 32'(wshb_cyc), 32'd0);
        tick();
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        @(negedge clk);
        chk("bp_level_after_pop", 32'(fifo_level), 32'd15);
        ok = wshb_cyc;
        if (!ok) begin
            @(negedge clk);
            ok = wshb_cyc;
        end
        chk("bp_cyc_resume", 32'(ok), 32'd1);
        tick();
        pix_ready = 1'b1;
        repeat (40) tick();

        // Fair play: a single idle cycle after every 64 acks
        do_restart();
        acks = 0; gaps = 0; g1 = -1; g2 = -1; dbl = 0; seen = 1'b0; prev_low = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wshb_cyc) begin
                seen = 1'b1;
                prev_low = 1'b0;
                if (wshb_ack) acks++;
            end else if (seen) begin
                gaps++;
                if (prev_low) dbl++;
                prev_low = 1'b1;
                if (gaps == 1) g1 = acks;
                if (gaps == 2) begin
                    g2 = acks;
                    break;
                end
            end
        end
        chk("fair_first_gap_acks", 32'(g1), 32'd64);
        chk("fair_second_gap_acks", 32'(g2), 32'd128);
        chk("fair_gap_len", 32'(dbl), 32'd0);
        tick();

        // Wait states: 3 wait cycles per transfer, address and strobe held
        wait_n = 4'd3;
        do_restart();
        acks = 0; stable_bad = 0; hold = 32'd0;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (wshb_cyc) begin
                if (wait_cnt == 4'd0) hold = wshb_adr;
                else if (wshb_adr !== hold || !wshb_stb) stable_bad++;
                if (wshb_ack) acks++;
            end
        end
        chk("ws_acks", 32'(acks), 32'd10);
        chk("ws_stable", 32'(stable_bad), 32'd0);
        tick();
        wait_n = 4'd0;

        // Restart with 5 buffered pixels and an ack in the same cycle
        pix_ready = 1'b0;
        do_restart();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_level == 5'd4) break;
        end
        tick();
        restart = 1'b1;
        @(negedge clk);
        chk("rs_pre_level", 32'(fifo_level), 32'd5);
        chk("rs_pre_ack", 32'(wshb_stb && wshb_ack), 32'd1);
        tick();
        restart = 1'b0;
        @(negedge clk);
        chk("rs_cyc", 32'(wshb_cyc), 32'd0);
        chk("rs_level", 32'(fifo_level), 32'd0);
        chk("rs_valid", 32'(pix_valid), 32'd0);
        chk("rs_adr", wshb_adr, 32'd0);
        tick();
        pix_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pix_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rs_first_valid", 32'(ok), 32'd1);
        chk("rs_first_sof", 32'(pix_sof), 32'd1);
        chk("rs_first_data", 32'(pix_data), 32'd0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_reader.md
Name: fb_reader

Overview:
- Wishbone classic read master that scans the SDRAM framebuffer sequentially, one 32-bit word per pixel.
- Buffers pixels in an internal FIFO and presents them to the display path as a valid/ready pixel stream.
- It is the read counterpart of the pattern/frame writer. It shares the same address map (4 bytes per pixel, HDISP*VDISP pixels from address 0) and the same fair-play arbitration rule toward the interconnect.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
FIFO_DEPTH, 16, pixel FIFO entries; power of 2, >= 2
FAIR_PERIOD, 64, acks between forced bus-release cycles

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wshb_cyc  out  1  Wishbone cycle
wshb_stb  out  1  Wishbone strobe
wshb_we  out  1  constant 0
wshb_sel  out  4  constant 4'hF
wshb_cti  out  3  constant 0 (classic)
wshb_bte  out  2  constant 0
wshb_adr  out  32  byte address
wshb_dat_sm  in  32  read data, slave to master
wshb_ack  in  1  transfer acknowledge
restart  in  1  synchronous frame resync / flush
pix_valid  out  1  FIFO head valid
pix_ready  in  1  consumer pops head when pix_valid & pix_ready
pix_data  out  24  RGB = dat_sm[23:0] of the head entry
pix_sof  out  1  head entry is pixel 0 of a frame
fifo_level  out  clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - cyc=stb=0, adr=0.
  - FIFO empty: pix_valid=0, fifo_level=0.
  - fair counter=0, state IDLE.
  - pix_data and pix_sof are don't-care while pix_valid=0.
- Priority: rst_n > restart > normal operation.
- cyc and stb are registered and always equal.
- States:
  - IDLE: cyc=stb=0. Next state is REQ when the FIFO is not full after this cycle's pop.
  - REQ: cyc=stb=1, adr is held stable until ack. On ack:
    - Push {adr==0, dat_sm[23:0]} into the FIFO.
    - Advance adr by 4; when adr==4*(HDISP*VDISP-1), wrap adr to 0.
    - Increment the fair counter.
    - If the fair counter was FAIR_PERIOD-1, clear it and go to GAP.
    - Else, if occupancy after this cycle (push plus any pop) equals FIFO_DEPTH, go to IDLE.
    - Else stay in REQ (back-to-back reads).
  - GAP: cyc=stb=0 for exactly one cycle. Then go to REQ if not full, else IDLE.
- Only one transfer is outstanding, so the FIFO can never overflow. An ack is ignored outside REQ.
- FIFO behaviour:
  - A push becomes visible the next cycle: ack at cycle t gives pix_valid=1 at t+1 when the FIFO was empty.
  - Simultaneous push and pop leaves the level unchanged, including when full.
  - A pop when empty is ignored.
  - First-word-fall-through: pix_data and pix_sof are stable while pix_valid=1 and pix_ready=0.
- restart=1 at a clock edge:
  - Next cycle: cyc=stb=0 (classic cycle abort), adr=0, FIFO flushed, level=0, fair counter=0, state IDLE.
  - An ack in the same cycle as restart is discarded.
  - A pop in the same cycle as restart is irrelevant.
  - Requests resume the following cycle if restart=0.
- Arithmetic:
  - The address wrap compare is full 32-bit.
  - The fair counter is clog2(FAIR_PERIOD) bits wide.
  - fifo_level is exact, 0..FIFO_DEPTH.
- Wait states: an arbitrary number of cycles between stb and ack is legal; adr and stb stay constant until ack.

Test Plan:
- Free-running read: release rst_n, slave acks every cycle with dat_sm=adr, pix_ready=1 -> cyc rises 1 cycle after reset release; adr sequence 0,4,8,…; pix_data=0x000000,0x000004,…; pix_sof=1 only on the first pixel.
- Backpressure: pix_ready=0 with immediate acks -> exactly 16 acks, then cyc=0 and fifo_level=16. Pulse pix_ready for one cycle -> level 15 and cyc=1 again within 2 cycles.
- Fair play: continuous ack, pix_ready=1 -> after the 64th ack cyc=stb=0 for exactly 1 cycle, then back-to-back again; after 128 acks, 2 gaps total.
- Frame wrap: HDISP=4, VDISP=2 -> after the ack at adr=28 the next adr is 0; the 9th pixel has pix_sof=1.
- Wait states: ack delayed 3 cycles per transfer -> adr and stb are constant during the wait; one FIFO push per ack; no duplicates or drops.
- Restart mid-transfer: FIFO holding 5 entries, stb=1, restart and ack in the same cycle -> next cycle cyc=0, fifo_level=0, pix_valid=0, adr=0; the next pushed pixel has pix_sof=1.
